msk_frame_sync: RTL and testbench

- Sits directly downstream of the MSK differential slicer/decoder. Consumes its hard-bit stream (one bit per data-valid pulse).
- Hunts for a programmable sync word with Hamming-distance tolerance, resolving the bit-polarity ambiguity from the true or inverted sync word.
- Packs the following fixed-length payload MSB-first into bytes and delivers them over a valid/ready stream through a 2-deep output buffer.

---
 rtl/msk_frame_pkg.sv | 28 ++
 rtl/msk_byte_fifo.sv | 57 +++++
 rtl/msk_frame_sync.sv | 157 +++++++++++++++
 tb/tb_msk_frame_sync.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_frame_pkg.sv
// MSK frame sync shared types and helpers.
// Sync-word defaults, FSM states and a width-bounded popcount.
package msk_frame_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int          DEF_SYNC_W    = 32;
  localparam logic [31:0] DEF_SYNC_WORD = 32'h1ACF_FC1D;
  localparam int          ERR_W         = $clog2(DEF_SYNC_W + 1);
  localparam int          POP_W         = 7;

  // Counts set bits in v[w-1:0]; supports words up to 64 bits.
  function automatic logic [POP_W-1:0] popcount(
    input logic [63:0] v,
    input int          w
  );
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/msk_byte_fifo.sv
// Two-entry byte+last FIFO between the frame packer and the stream port.
// A push into a full FIFO with no pop in the same cycle is dropped.
module msk_byte_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [8:0] data_i,
  input  logic       pop_i,
  output logic [8:0] data_o,
  output logic       empty_o,
  output logic       ovf_o
);

  logic [8:0] mem_q [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       full;
  logic       do_pop;
  logic       do_push;

  assign full    = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ~wr_q;
    if (do_pop)  rd_d = ~rd_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_q] <= data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msk_frame_sync.sv
// Sync-word hunter and payload byte packer for the MSK hard-bit stream.
// Resolves polarity from a true or inverted sync match.
module msk_frame_sync
  import msk_frame_pkg::*;
#(
  parameter int                SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter int                MAX_ERR     = 2,
  parameter int                FRAME_BYTES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_i,
  input  logic                         data_valid_i,
  output logic [7:0]                   byte_o,
  output logic                         byte_last_o,
  output logic                         byte_valid_o,
  input  logic                         byte_ready_i,
  output logic                         sync_det_o,
  output logic                         locked_o,
  output logic                         invert_o,
  output logic [$clog2(SYNC_W+1)-1:0]  sync_errs_o,
  output logic                         overflow_o
);

  localparam int EW = $clog2(SYNC_W + 1);
  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [EW-1:0]    FILL_MAX = EW'(SYNC_W);
  localparam logic [BW-1:0]    LAST_IDX = BW'(FRAME_BYTES - 1);
  localparam logic [POP_W-1:0] MAX_E    = POP_W'(MAX_ERR);

  state_t            state_q, state_d;
  logic [SYNC_W-2:0] sr_q, sr_d;
  logic [EW-1:0]     fill_q, fill_d;
  logic [6:0]        acc_q, acc_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic              invert_q, invert_d;
  logic [EW-1:0]     errs_q, errs_d;
  logic              det_q, det_d;
  logic              ovf_q, ovf_d;

  logic [SYNC_W-1:0] sr_next;
  logic [POP_W-1:0]  errs_n;
  logic [POP_W-1:0]  errs_i;
  logic              match_en;
  logic              pbit;
  logic              is_last;
  logic              push;
  logic [8:0]        push_data;
  logic [8:0]        fifo_data;
  logic              fifo_empty;
  logic              fifo_ovf;

  assign sr_next  = {sr_q, data_i};
  assign errs_n   = popcount(64'(sr_next ^ SYNC_WORD), SYNC_W);
  assign errs_i   = popcount(64'(sr_next ^ ~SYNC_WORD), SYNC_W);
  assign match_en = (fill_q >= FILL_MAX - 1'b1);
  assign pbit     = data_i ^ invert_q;
  assign is_last  = (byte_cnt_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    invert_d   = invert_q;
    errs_d     = errs_q;
    det_d      = 1'b0;
    ovf_d      = ovf_q | fifo_ovf;
    push       = 1'b0;
    push_data  = '0;
    if (data_valid_i) begin
      sr_d = sr_next[SYNC_W-2:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      unique case (state_q)
        SEARCH: begin
          if (match_en && (errs_n <= MAX_E || errs_i <= MAX_E)) begin
            state_d    = PAYLOAD;
            det_d      = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            // Normal polarity takes priority when both match.
            invert_d   = !(errs_n <= MAX_E);
            errs_d     = (errs_n <= MAX_E) ? errs_n[EW-1:0]
                                           : errs_i[EW-1:0];
          end
        end
        PAYLOAD: begin
          acc_d     = {acc_q[5:0], pbit};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push      = 1'b1;
            push_data = {is_last, acc_q, pbit};
            if (is_last) begin
              state_d    = SEARCH;
              fill_d     = '0;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= '0;
      fill_q     <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      invert_q   <= 1'b0;
      errs_q     <= '0;
      det_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      invert_q   <= invert_d;
      errs_q     <= errs_d;
      det_q      <= det_d;
      ovf_q      <= ovf_d;
    end
  end

  msk_byte_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (byte_ready_i),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .ovf_o   (fifo_ovf)
  );

  assign byte_o       = fifo_data[7:0];
  assign byte_last_o  = fifo_data[8];
  assign byte_valid_o = !fifo_empty;
  assign sync_det_o   = det_q;
  assign locked_o     = (state_q == PAYLOAD);
  assign invert_o     = invert_q;
  assign sync_errs_o  = errs_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed bench for msk_frame_sync with a 4-byte frame.
// Table rows cover polarity/error cases; hand sequences cover the rest.
module tb_msk_frame_sync;

  localparam logic [31:0] SW = 32'h1ACF_FC1D;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_i;
  logic       data_valid_i;
  logic       byte_ready_i;
  logic [7:0] byte_o;
  logic       byte_last_o;
  logic       byte_valid_o;
  logic       sync_det_o;
  logic       locked_o;
  logic       invert_o;
  logic [5:0] sync_errs_o;
  logic       overflow_o;

  msk_frame_sync #(
    .SYNC_W      (32),
    .SYNC_WORD   (SW),
    .MAX_ERR     (2),
    .FRAME_BYTES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .byte_o       (byte_o),
    .byte_last_o  (byte_last_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .sync_det_o   (sync_det_o),
    .locked_o     (locked_o),
    .invert_o     (invert_o),
    .sync_errs_o  (sync_errs_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         det_cnt = 0;
  logic [8:0] rxq [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid_o && byte_ready_i) rxq.push_back({byte_last_o, byte_o});
      if (sync_det_o) det_cnt++;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] word;
    int          prefix;
    logic [31:0] pay;
    logic [31:0] exp_pay;
    logic        exp_lock;
    logic        exp_inv;
    logic [5:0]  exp_errs;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    idle(gap);
    data_i       = b;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    data_i       = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], int'($urandom_range(0, 2)));
  endtask

  // Last bit goes with a one-cycle gap so the caller sits just after its edge.
  task automatic send_sync(input logic [31:0] w);
    send_bits(64'(w >> 1), 31);
    send_bit(w[0], 1);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    data_valid_i = 1'b0;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(byte_valid_o), 64'd0);
    chk({tag, "_byte"},  64'(byte_o),       64'd0);
    chk({tag, "_last"},  64'(byte_last_o),  64'd0);
    chk({tag, "_det"},   64'(sync_det_o),   64'd0);
    chk({tag, "_lock"},  64'(locked_o),     64'd0);
    chk({tag, "_inv"},   64'(invert_o),     64'd0);
    chk({tag, "_errs"},  64'(sync_errs_o),  64'd0);
    chk({tag, "_ovf"},   64'(overflow_o),   64'd0);
  endtask

  initial begin
    int rb;
    int db;
    vecs[0] = '{"plain",    32'h1ACF_FC1D, 100, 32'hA53C_FF01,
                32'hA53C_FF01, 1'b1, 1'b0, 6'd0};
    vecs[1] = '{"inv",      32'hE530_03E2, 20,  32'h5AC3_00FE,
                32'hA53C_FF01, 1'b1, 1'b1, 6'd0};
    vecs[2] = '{"err2",     32'h1ACE_FC1C, 20,  32'h5A0F_3C96,
                32'h5A0F_3C96, 1'b1, 1'b0, 6'd2};
    vecs[3] = '{"err3",     32'h9ACE_FC1C, 20,  32'h5A0F_3C96,
                32'h5A0F_3C96, 1'b0, 1'b0, 6'd0};
    vecs[4] = '{"inv_err2", 32'hE530_00E2, 20,  32'hEDCB_A987,
                32'h1234_5678, 1'b1, 1'b1, 6'd2};

    data_i       = 1'b0;
    data_valid_i = 1'b0;
    byte_ready_i = 1'b1;
    do_reset();
    chk_idle_outputs("rst");

    for (int v = 0; v < 5; v++) begin
      do_reset();
      byte_ready_i = 1'b1;
      rb = rxq.size();
      db = det_cnt;
      for (int i = 0; i < vecs[v].prefix; i++)
        send_bit(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      send_sync(vecs[v].word);
      chk({vecs[v].name, "_det_pulse"}, 64'(sync_det_o), 64'(vecs[v].exp_lock));
      chk({vecs[v].name, "_locked"},    64'(locked_o),   64'(vecs[v].exp_lock));
      idle(1);
      chk({vecs[v].name, "_det_1cyc"},  64'(sync_det_o), 64'd0);
      send_bits(64'(vecs[v].pay), 32);
      idle(6);
      chk({vecs[v].name, "_det_cnt"}, 64'(det_cnt - db), 64'(vecs[v].exp_lock));
      chk({vecs[v].name, "_nbytes"},  64'(rxq.size() - rb),
          vecs[v].exp_lock ? 64'd4 : 64'd0);
      if (vecs[v].exp_lock && rxq.size() - rb == 4) begin
        for (int i = 0; i < 4; i++) begin
          logic [31:0] p;
          p = vecs[v].exp_pay;
          chk({vecs[v].name, "_byte"}, 64'(rxq[rb+i]),
              64'({(i == 3), p[31-8*i -: 8]}));
        end
      end
      chk({vecs[v].name, "_unlock"}, 64'(locked_o),    64'd0);
      chk({vecs[v].name, "_inv"},    64'(invert_o),    64'(vecs[v].exp_inv));
      chk({vecs[v].name, "_errs"},   64'(sync_errs_o), 64'(vecs[v].exp_errs));
    end

    // Sync as the very first word, then a straddling copy that must not lock.
    do_reset();
    rb = rxq.size();
    db = det_cnt;
    send_sync(SW);
    chk("strad_first_det", 64'(sync_det_o), 64'd1);
    send_bits(64'h0001_ACFF, 32);
    send_bits(64'(SW[11:0]), 12);
    idle(6);
    chk("strad_no_relock", 64'(det_cnt - db), 64'd1);
    chk("strad_unlocked",  64'(locked_o),     64'd0);
    chk("strad_nbytes",    64'(rxq.size() - rb), 64'd4);
    if (rxq.size() - rb == 4) begin
      chk("strad_b0", 64'(rxq[rb+0]), 64'h000);
      chk("strad_b1", 64'(rxq[rb+1]), 64'h001);
      chk("strad_b2", 64'(rxq[rb+2]), 64'h0AC);
      chk("strad_b3", 64'(rxq[rb+3]), 64'h1FF);
    end
    send_sync(SW);
    chk("strad_relock", 64'(sync_det_o), 64'd1);
    send_bits(64'h0102_0304, 32);
    idle(6);
    chk("strad_det_total", 64'(det_cnt - db),     64'd2);
    chk("strad_nbytes2",   64'(rxq.size() - rb),  64'd8);
    if (rxq.size() - rb == 8) chk("strad_b7", 64'(rxq[rb+7]), 64'h104);

    // Backpressure for a whole frame: two bytes held, two dropped.
    do_reset();
    byte_ready_i = 1'b0;
    rb = rxq.size();
    send_sync(SW);
    send_bits(64'h08, 7);
    chk("bp_not_yet", 64'(byte_valid_o), 64'd0);
    send_bit(1'b1, 1);
    chk("bp_valid_rise", 64'(byte_valid_o), 64'd1);
    chk("bp_first_byte", 64'(byte_o),       64'h11);
    send_bits(64'h22_3344, 24);
    idle(5);
    chk("bp_hold_byte", 64'(byte_o),       64'h11);
    chk("bp_hold_last", 64'(byte_last_o),  64'd0);
    chk("bp_hold_vld",  64'(byte_valid_o), 64'd1);
    chk("bp_ovf",       64'(overflow_o),   64'd1);
    chk("bp_unlock",    64'(locked_o),     64'd0);
    idle(3);
    chk("bp_ovf_sticky", 64'(overflow_o), 64'd1);
    byte_ready_i = 1'b1;
    idle(5);
    chk("bp_nxfers", 64'(rxq.size() - rb), 64'd2);
    if (rxq.size() - rb == 2) begin
      chk("bp_x0", 64'(rxq[rb+0]), 64'h011);
      chk("bp_x1", 64'(rxq[rb+1]), 64'h022);
    end
    chk("bp_drained",  64'(byte_valid_o), 64'd0);
    chk("bp_ovf_keep", 64'(overflow_o),   64'd1);

    // Reset in the middle of a payload with bytes buffered.
    do_reset();
    byte_ready_i = 1'b0;
    send_sync(32'hE530_03E3);
    send_bits(64'h4110, 16);
    send_bits(64'h5, 3);
    chk("mid_pre_vld",  64'(byte_valid_o), 64'd1);
    chk("mid_pre_inv",  64'(invert_o),     64'd1);
    chk("mid_pre_errs", 64'(sync_errs_o),  64'd1);
    chk("mid_pre_lock", 64'(locked_o),     64'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk_idle_outputs("mid_rst");
    byte_ready_i = 1'b1;
    rb = rxq.size();
    send_sync(SW);
    send_bits(64'hCAFE_F00D, 32);
    idle(6);
    chk("mid_nbytes", 64'(rxq.size() - rb), 64'd4);
    if (rxq.size() - rb == 4) begin
      chk("mid_b0", 64'(rxq[rb+0]), 64'h0CA);
      chk("mid_b3", 64'(rxq[rb+3]), 64'h10D);
    end
    chk("mid_inv", 64'(invert_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
